sync_fifo_fwft: RTL and testbench



---
 rtl/sync_fifo_fwft_ram.sv | 26 ++
 rtl/sync_fifo_fwft.sv | 87 ++++++++
 tb/tb_sync_fifo_fwft.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_fwft_ram.sv
// Simple dual-port storage for the FWFT FIFO: synchronous write, asynchronous read.
module sync_fifo_fwft_ram #(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH_WIDTH = 3
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [DEPTH_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]  wdata,
    input  logic [DEPTH_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0]  rdata
);

    localparam int DEPTH = 2 ** DEPTH_WIDTH;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO with registered flags, count and head word.
module sync_fifo_fwft #(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH_WIDTH = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  din,
    input  logic                   wr_en,
    output logic                   full,
    output logic [DATA_WIDTH-1:0]  dout,
    input  logic                   rd_en,
    output logic                   empty,
    output logic [DEPTH_WIDTH-1:0] cnt
);

    if (DATA_WIDTH < 1) begin : g_bad_data_width
        $fatal(1, "sync_fifo_fwft: DATA_WIDTH must be >= 1");
    end
    if (DEPTH_WIDTH < 1) begin : g_bad_depth_width
        $fatal(1, "sync_fifo_fwft: DEPTH_WIDTH must be >= 1");
    end

    localparam logic [DEPTH_WIDTH-1:0] CAPACITY = {DEPTH_WIDTH{1'b1}};
    localparam logic [DEPTH_WIDTH-1:0] ONE      = DEPTH_WIDTH'(1);

    logic [DEPTH_WIDTH-1:0] wr_ptr;
    logic [DEPTH_WIDTH-1:0] rd_ptr;
    logic [DEPTH_WIDTH-1:0] cnt_next;
    logic [DATA_WIDTH-1:0]  next_head;
    logic                   wr_acc;
    logic                   rd_acc;

    assign wr_acc = wr_en & ~full;
    assign rd_acc = rd_en & ~empty;

    always_comb begin
        cnt_next = cnt;
        if (wr_acc && !rd_acc) begin
            cnt_next = cnt + ONE;
        end else if (rd_acc && !wr_acc) begin
            cnt_next = cnt - ONE;
        end
    end

    // The word behind the head is pre-read so a pop refreshes dout with no bubble.
    sync_fifo_fwft_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_WIDTH(DEPTH_WIDTH)
    ) u_ram (
        .clk  (clk),
        .we   (wr_acc),
        .waddr(wr_ptr),
        .wdata(din),
        .raddr(rd_ptr + ONE),
        .rdata(next_head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
            dout   <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + ONE;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + ONE;
            end
            cnt   <= cnt_next;
            empty <= (cnt_next == '0);
            full  <= (cnt_next == CAPACITY);
            // Memory only supplies the new head when it was written on an earlier edge;
            // a word landing in an empty (or just-emptied) FIFO bypasses straight from din.
            if (rd_acc && (cnt > ONE)) begin
                dout <= next_head;
            end else if (wr_acc && (empty || (rd_acc && (cnt == ONE)))) begin
                dout <= din;
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Self-checking bench for sync_fifo_fwft: directed vector table, corner sequences, random vs queue model.
module tb_sync_fifo_fwft;

    localparam int DW  = 8;
    localparam int AW  = 3;
    localparam int CAP = 7;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] din = '0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic          full;
    logic          empty;
    logic [DW-1:0] dout;
    logic [AW-1:0] cnt;

    int check_count = 0;
    int pass_count  = 0;

    logic [DW-1:0] model_q[$];
    logic [DW-1:0] model_head = '0;

    typedef struct {
        logic          rs;
        logic          wr;
        logic          rd;
        logic [DW-1:0] data;
        logic          exp_empty;
        logic          exp_full;
        logic [AW-1:0] exp_cnt;
        logic [DW-1:0] exp_dout;
    } vec_t;

    vec_t vecs[$];

    sync_fifo_fwft #(
        .DATA_WIDTH (DW),
        .DEPTH_WIDTH(AW)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .din  (din),
        .wr_en(wr_en),
        .full (full),
        .dout (dout),
        .rd_en(rd_en),
        .empty(empty),
        .cnt  (cnt)
    );

    always #5 clk = ~clk;

    function automatic void add_vec(logic rs, logic wr, logic rd, logic [DW-1:0] data,
                                    logic ee, logic ef, logic [AW-1:0] ec, logic [DW-1:0] ed);
        vec_t v;
        v.rs = rs; v.wr = wr; v.rd = rd; v.data = data;
        v.exp_empty = ee; v.exp_full = ef; v.exp_cnt = ec; v.exp_dout = ed;
        vecs.push_back(v);
    endfunction

    // Drives one cycle of inputs, lets the edge happen, advances the model, and returns on the falling edge.
    task automatic applyStimulus(input logic rs, input logic wr, input logic rd, input logic [DW-1:0] data);
        bit was_full;
        bit was_empty;
        rst = rs; wr_en = wr; rd_en = rd; din = data;
        @(posedge clk);
        if (rs) begin
            model_q.delete();
            model_head = '0;
        end else begin
            was_full  = (model_q.size() == CAP);
            was_empty = (model_q.size() == 0);
            if (rd && !was_empty) void'(model_q.pop_front());
            if (wr && !was_full) model_q.push_back(data);
            if (model_q.size() > 0) model_head = model_q[0];
        end
        @(negedge clk);
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [DW-1:0] ed, input logic ee,
                               input logic ef, input logic [AW-1:0] ec);
        check_count++;
        if (dout !== ed || empty !== ee || full !== ef || cnt !== ec) begin
            $display("[TB] FAIL %s: got dout=%h empty=%b full=%b cnt=%0d, expected dout=%h empty=%b full=%b cnt=%0d",
                     name, dout, empty, full, cnt, ed, ee, ef, ec);
        end else begin
            pass_count++;
        end
    endtask

    task automatic checkModel(input string name);
        checkOutput(name, model_head, model_q.size() == 0, model_q.size() == CAP, AW'(model_q.size()));
    endtask

    initial begin
        logic [DW-1:0] seq_word;
        int            bias;
        bit            w;
        bit            r;

        // Directed table: reset, single word, fill/overflow, drain, empty with both strobes.
        add_vec(1, 0, 0, 8'h00, 1, 0, 3'd0, 8'h00);
        add_vec(0, 0, 1, 8'h00, 1, 0, 3'd0, 8'h00);
        add_vec(0, 1, 0, 8'hA5, 0, 0, 3'd1, 8'hA5);
        add_vec(0, 0, 1, 8'h00, 1, 0, 3'd0, 8'hA5);
        for (int i = 1; i <= 7; i++)
            add_vec(0, 1, 0, 8'(i), 0, (i == 7), 3'(i), 8'h01);
        add_vec(0, 1, 0, 8'hFF, 0, 1, 3'd7, 8'h01);
        for (int i = 1; i <= 7; i++)
            add_vec(0, 0, 1, 8'h00, (i == 7), 0, 3'(7 - i), (i == 7) ? 8'h07 : 8'(i + 1));
        add_vec(0, 1, 1, 8'h3C, 0, 0, 3'd1, 8'h3C);
        add_vec(0, 0, 1, 8'h00, 1, 0, 3'd0, 8'h3C);

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rs, vecs[i].wr, vecs[i].rd, vecs[i].data);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_dout, vecs[i].exp_empty,
                        vecs[i].exp_full, vecs[i].exp_cnt);
        end

        // Steady read+write at occupancy 3, long enough to wrap both pointers several times.
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 8'(8'h10 + i));
        checkOutput("prefill3", 8'h10, 0, 0, 3'd3);
        for (int k = 0; k < 20; k++) begin
            applyStimulus(0, 1, 1, 8'(8'h20 + k));
            seq_word = (k + 1 < 3) ? 8'(8'h10 + k + 1) : 8'(8'h20 + k - 2);
            checkOutput($sformatf("rw_steady%0d", k), seq_word, 0, 0, 3'd3);
        end

        // Full with both strobes: pop wins, the write is dropped.
        while (model_q.size() < CAP) applyStimulus(0, 1, 0, 8'h50 + 8'(model_q.size()));
        checkModel("fill_to_full");
        applyStimulus(0, 1, 1, 8'hEE);
        checkModel("full_rw");
        checkOutput("full_rw_cnt", model_head, 0, 0, 3'd6);
        for (int k = 0; k < 6; k++) begin
            applyStimulus(0, 0, 1, 8'h00);
            checkModel($sformatf("drain_after_full_rw%0d", k));
        end

        // Random traffic with phase-varying write bias and occasional mid-stream reset.
        for (int c = 0; c < 10000; c++) begin
            case ((c / 500) % 3)
                0:       bias = 80;
                1:       bias = 20;
                default: bias = 50;
            endcase
            w = ($urandom_range(0, 99) < bias);
            r = ($urandom_range(0, 99) < (100 - bias));
            if ($urandom_range(0, 499) == 0) begin
                applyStimulus(1, w, r, 8'($urandom));
                checkOutput($sformatf("rand_rst%0d", c), 8'h00, 1, 0, 3'd0);
            end else begin
                applyStimulus(0, w, r, 8'($urandom));
                checkModel($sformatf("rand%0d", c));
            end
        end

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
